// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encodings, default opcodes and the IR capture pattern.
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_EX2DR = 4'h0,
        TAP_EX1DR = 4'h1,
        TAP_SHDR  = 4'h2,
        TAP_PAUDR = 4'h3,
        TAP_SELIR = 4'h4,
        TAP_UPDDR = 4'h5,
        TAP_CAPDR = 4'h6,
        TAP_SELDR = 4'h7,
        TAP_EX2IR = 4'h8,
        TAP_EX1IR = 4'h9,
        TAP_SHIR  = 4'hA,
        TAP_PAUIR = 4'hB,
        TAP_RTI   = 4'hC,
        TAP_UPDIR = 4'hD,
        TAP_CAPIR = 4'hE,
        TAP_TLR   = 4'hF
    } tap_state_t;

    localparam int         IR_LENGTH_DEF   = 4;
    localparam logic [3:0] INS_BYPASS_DEF  = 4'b1111;
    localparam logic [3:0] INS_IDCODE_DEF  = 4'b0001;
    localparam logic [3:0] INS_USER_DR_DEF = 4'b0010;
    // The two LSBs every IR capture must present; upper bits are zero.
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

endpackage

// File: rtl/jtag_tap_ctrl_fsm.sv
// 16-state TAP state machine driven by TMS, with Moore decode of the DR strobes.
module tap_fsm
    import jtag_pkg::*;
(
    input  logic       i_tck,
    input  logic       i_trst,
    input  logic       i_tms,
    output logic [3:0] o_state,
    output logic [3:0] o_next_state,
    output logic       o_capture_dr,
    output logic       o_shift_dr,
    output logic       o_update_dr
);

    tap_state_t r_state;
    tap_state_t w_next;

    // State register, forced to Test-Logic-Reset asynchronously by TRST.
    always_ff @(posedge i_tck or posedge i_trst) begin
        if (i_trst) begin
            r_state <= TAP_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: first branch is TMS=0, second is TMS=1.
    always_comb begin
        w_next = TAP_TLR;
        case (r_state)
            TAP_TLR:   if (i_tms) w_next = TAP_TLR;   else w_next = TAP_RTI;
            TAP_RTI:   if (i_tms) w_next = TAP_SELDR; else w_next = TAP_RTI;
            TAP_SELDR: if (i_tms) w_next = TAP_SELIR; else w_next = TAP_CAPDR;
            TAP_CAPDR: if (i_tms) w_next = TAP_EX1DR; else w_next = TAP_SHDR;
            TAP_SHDR:  if (i_tms) w_next = TAP_EX1DR; else w_next = TAP_SHDR;
            TAP_EX1DR: if (i_tms) w_next = TAP_UPDDR; else w_next = TAP_PAUDR;
            TAP_PAUDR: if (i_tms) w_next = TAP_EX2DR; else w_next = TAP_PAUDR;
            TAP_EX2DR: if (i_tms) w_next = TAP_UPDDR; else w_next = TAP_SHDR;
            TAP_UPDDR: if (i_tms) w_next = TAP_SELDR; else w_next = TAP_RTI;
            TAP_SELIR: if (i_tms) w_next = TAP_TLR;   else w_next = TAP_CAPIR;
            TAP_CAPIR: if (i_tms) w_next = TAP_EX1IR; else w_next = TAP_SHIR;
            TAP_SHIR:  if (i_tms) w_next = TAP_EX1IR; else w_next = TAP_SHIR;
            TAP_EX1IR: if (i_tms) w_next = TAP_UPDIR; else w_next = TAP_PAUIR;
            TAP_PAUIR: if (i_tms) w_next = TAP_EX2IR; else w_next = TAP_PAUIR;
            TAP_EX2IR: if (i_tms) w_next = TAP_UPDIR; else w_next = TAP_SHIR;
            TAP_UPDIR: if (i_tms) w_next = TAP_SELDR; else w_next = TAP_RTI;
            default:   w_next = TAP_TLR;
        endcase
    end

    // Strobes decode the current state; the DR acts on the edge that leaves it.
    always_comb begin
        o_capture_dr = 1'b0;
        o_shift_dr   = 1'b0;
        o_update_dr  = 1'b0;
        case (r_state)
            TAP_CAPDR: o_capture_dr = 1'b1;
            TAP_SHDR:  o_shift_dr   = 1'b1;
            TAP_UPDDR: o_update_dr  = 1'b1;
            default: begin
                o_capture_dr = 1'b0;
                o_shift_dr   = 1'b0;
                o_update_dr  = 1'b0;
            end
        endcase
    end

    assign o_state      = r_state;
    assign o_next_state = w_next;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller top: instruction register, BYPASS and IDCODE registers and TDO mux.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int                   IR_LENGTH   = IR_LENGTH_DEF,
    parameter logic [31:0]          IDCODE_VAL  = 32'h1000_0001,
    parameter logic [IR_LENGTH-1:0] INS_BYPASS  = {IR_LENGTH{1'b1}},
    parameter logic [IR_LENGTH-1:0] INS_IDCODE  = IR_LENGTH'(INS_IDCODE_DEF),
    parameter logic [IR_LENGTH-1:0] INS_USER_DR = IR_LENGTH'(INS_USER_DR_DEF)
) (
    input  logic                 TCK,
    input  logic                 TRST,
    input  logic                 TMS,
    input  logic                 TDI,
    input  logic                 DR_TDO,
    output logic                 TDO,
    output logic                 TDO_EN,
    output logic                 tdr_select,
    output logic                 Capture_DR,
    output logic                 Shift_DR,
    output logic                 Update_DR,
    output logic [IR_LENGTH-1:0] IR_OUT,
    output logic [3:0]           tap_state
);

    localparam logic [IR_LENGTH-1:0] IR_CAPTURE = {{(IR_LENGTH-2){1'b0}}, IR_CAPTURE_LSBS};

    logic [3:0]           w_state;
    logic [3:0]           w_next;
    logic                 w_sel_idcode;
    logic                 w_sel_user;
    logic                 w_sel_bypass;
    logic                 w_tdo;
    logic [IR_LENGTH-1:0] r_ir;
    logic [IR_LENGTH-1:0] r_ir_sr;
    logic                 r_bypass;
    logic [31:0]          r_idcode_sr;

    tap_fsm u_fsm (
        .i_tck        (TCK),
        .i_trst       (TRST),
        .i_tms        (TMS),
        .o_state      (w_state),
        .o_next_state (w_next),
        .o_capture_dr (Capture_DR),
        .o_shift_dr   (Shift_DR),
        .o_update_dr  (Update_DR)
    );

    // Undefined opcodes fall back to BYPASS so the chain length stays well defined.
    assign w_sel_idcode = (r_ir == INS_IDCODE);
    assign w_sel_user   = (r_ir == INS_USER_DR);
    assign w_sel_bypass = !w_sel_idcode && !w_sel_user;

    // Instruction register: forced to IDCODE while in or entering TLR, updated on leaving UpdIR.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_ir <= INS_IDCODE;
        end else if ((w_state == TAP_TLR) || (w_next == TAP_TLR)) begin
            r_ir <= INS_IDCODE;
        end else if (w_state == TAP_UPDIR) begin
            r_ir <= r_ir_sr;
        end else begin
            r_ir <= r_ir;
        end
    end

    // IR shift stage: capture pattern, then shift left with TDI into the LSB.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_ir_sr <= '0;
        end else if (w_state == TAP_CAPIR) begin
            r_ir_sr <= IR_CAPTURE;
        end else if (w_state == TAP_SHIR) begin
            r_ir_sr <= {r_ir_sr[IR_LENGTH-2:0], TDI};
        end else begin
            r_ir_sr <= r_ir_sr;
        end
    end

    // BYPASS bit: captures 0 and loads TDI, only while selected.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_bypass <= 1'b0;
        end else if (w_sel_bypass && (w_state == TAP_CAPDR)) begin
            r_bypass <= 1'b0;
        end else if (w_sel_bypass && (w_state == TAP_SHDR)) begin
            r_bypass <= TDI;
        end else begin
            r_bypass <= r_bypass;
        end
    end

    // IDCODE shift register, only while selected.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_idcode_sr <= IDCODE_VAL;
        end else if (w_sel_idcode && (w_state == TAP_CAPDR)) begin
            r_idcode_sr <= IDCODE_VAL;
        end else if (w_sel_idcode && (w_state == TAP_SHDR)) begin
            r_idcode_sr <= {r_idcode_sr[30:0], TDI};
        end else begin
            r_idcode_sr <= r_idcode_sr;
        end
    end

    // TDO source select by current state and active instruction.
    always_comb begin
        w_tdo = 1'b0;
        case (w_state)
            TAP_SHIR: w_tdo = r_ir_sr[IR_LENGTH-1];
            TAP_SHDR: begin
                if (w_sel_user) begin
                    w_tdo = DR_TDO;
                end else if (w_sel_idcode) begin
                    w_tdo = r_idcode_sr[31];
                end else begin
                    w_tdo = r_bypass;
                end
            end
            default: w_tdo = 1'b0;
        endcase
    end

    assign TDO        = w_tdo;
    assign TDO_EN     = (w_state == TAP_SHIR) || (w_state == TAP_SHDR);
    assign tdr_select = w_sel_user;
    assign IR_OUT     = r_ir;
    assign tap_state  = w_state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl with a 5-bit user data register model on the DR chain.
module tb_jtag_tap_ctrl;

    logic       TCK = 1'b0;
    logic       TRST;
    logic       TMS;
    logic       TDI;
    logic       DR_TDO;
    logic       TDO;
    logic       TDO_EN;
    logic       tdr_select;
    logic       Capture_DR;
    logic       Shift_DR;
    logic       Update_DR;
    logic [3:0] IR_OUT;
    logic [3:0] tap_state;

    int total = 0;
    int bad   = 0;
    int cap_cnt = 0;
    int upd_cnt = 0;
    int c0;

    logic [4:0] dr_sr  = 5'b00000;
    logic [4:0] dr_out = 5'b00000;

    localparam logic [31:0] IDV = 32'h1000_0001;

    jtag_tap_ctrl dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .DR_TDO     (DR_TDO),
        .TDO        (TDO),
        .TDO_EN     (TDO_EN),
        .tdr_select (tdr_select),
        .Capture_DR (Capture_DR),
        .Shift_DR   (Shift_DR),
        .Update_DR  (Update_DR),
        .IR_OUT     (IR_OUT),
        .tap_state  (tap_state)
    );

    always #5 TCK = ~TCK;

    // External Data_Reg: captures all ones, shifts MSB out, updates DR_OUT on Update_DR.
    always @(posedge TCK) begin
        if (tdr_select && Capture_DR) dr_sr <= 5'b11111;
        else if (tdr_select && Shift_DR) dr_sr <= {dr_sr[3:0], TDI};
        if (tdr_select && Update_DR) dr_out <= dr_sr;
        if (Capture_DR) cap_cnt = cap_cnt + 1;
        if (Update_DR) upd_cnt = upd_cnt + 1;
    end
    assign DR_TDO = dr_sr[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
    endtask

    task automatic ir_scan(input logic [3:0] bits);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("ir_tdo_en", 32'(TDO_EN), 32'd1);
        for (int i = 3; i >= 0; i--) begin
            check("ir_capture_tdo", 32'(TDO), (i == 0) ? 32'd1 : 32'd0);
            step(i == 0, bits[i]);
        end
        step(1'b1, 1'b0);
        check("upd_ir_state", 32'(tap_state), 32'hD);
        step(1'b0, 1'b0);
    endtask

    initial begin
        TRST = 1'b1;
        TMS  = 1'b1;
        TDI  = 1'b0;
        #12;
        check("rst_state", 32'(tap_state), 32'hF);
        check("rst_ir", 32'(IR_OUT), 32'h1);
        check("rst_strobes", 32'({Capture_DR, Shift_DR, Update_DR, tdr_select}), 32'h0);
        check("rst_tdo", 32'({TDO_EN, TDO}), 32'h0);
        @(negedge TCK);
        TRST = 1'b0;

        // Random walks, then five TMS=1 clocks must land in TLR.
        for (int k = 0; k < 3; k++) begin
            int n;
            n = $urandom_range(2, 12);
            for (int j = 0; j < n; j++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int j = 0; j < 5; j++) step(1'b1, 1'b0);
            check("tms5_state", 32'(tap_state), 32'hF);
            check("tms5_ir", 32'(IR_OUT), 32'h1);
            check("tms5_tdo_en", 32'(TDO_EN), 32'h0);
            check("tms5_strobes", 32'({Capture_DR, Shift_DR, Update_DR}), 32'h0);
        end

        // IDCODE read
        step(1'b0, 1'b0);
        check("rti_state", 32'(tap_state), 32'hC);
        c0 = cap_cnt;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("capdr_strobe", 32'(Capture_DR), 32'd1);
        step(1'b0, 1'b0);
        check("shdr_state", 32'(tap_state), 32'h2);
        for (int i = 0; i < 32; i++) begin
            check("idcode_tdo", 32'(TDO), 32'(IDV[31-i]));
            step(i == 31, 1'b0);
        end
        check("idcode_cap_once", 32'(cap_cnt - c0), 32'd1);
        check("ex1dr_state", 32'(tap_state), 32'h1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Load USER_DR
        ir_scan(4'b0010);
        check("user_ir", 32'(IR_OUT), 32'h2);
        check("user_sel", 32'(tdr_select), 32'd1);

        // User DR scan
        c0 = upd_cnt;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        begin
            logic [4:0] din;
            din = 5'b10110;
            for (int i = 4; i >= 0; i--) begin
                check("user_tdo", 32'(TDO), 32'd1);
                step(i == 0, din[i]);
            end
        end
        step(1'b1, 1'b0);
        check("upddr_strobe", 32'(Update_DR), 32'd1);
        step(1'b0, 1'b0);
        check("upddr_low", 32'(Update_DR), 32'd0);
        check("user_dr_out", 32'(dr_out), 32'h16);
        check("upd_once", 32'(upd_cnt - c0), 32'd1);

        // BYPASS
        ir_scan(4'b1111);
        check("byp_ir", 32'(IR_OUT), 32'hF);
        check("byp_sel", 32'(tdr_select), 32'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        begin
            logic [7:0] din;
            logic [7:0] dexp;
            din  = 8'b10110011;
            dexp = 8'b01011001;
            for (int i = 7; i >= 0; i--) begin
                check("byp_tdo", 32'(TDO), 32'(dexp[i]));
                step(i == 0, din[i]);
            end
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // TRST mid-shift
        ir_scan(4'b0010);
        check("user2_sel", 32'(tdr_select), 32'd1);
        c0 = upd_cnt;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("mid_shdr", 32'(tap_state), 32'h2);
        #2;
        TRST = 1'b1;
        #1;
        check("trst_state", 32'(tap_state), 32'hF);
        check("trst_ir", 32'(IR_OUT), 32'h1);
        check("trst_sel", 32'(tdr_select), 32'd0);
        check("trst_outs", 32'({TDO_EN, TDO, Shift_DR}), 32'h0);
        @(negedge TCK);
        TRST = 1'b0;
        for (int j = 0; j < 3; j++) step(1'b1, 1'b0);
        check("trst_no_upd", 32'(upd_cnt - c0), 32'd0);
        check("trst_dr_out", 32'(dr_out), 32'h16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
IEEE 1149.1-style TAP controller for the team's JTAG test-data-register chain. It decodes TMS into the 16-state TAP FSM and owns the instruction register. It drives the Capture_DR/Shift_DR/Update_DR strobes and tdr_select into the user data register, and hosts the internal BYPASS and IDCODE registers. It also muxes the selected register onto TDO. It sits between the chip's JTAG pins and every Data_Reg-style user register.

Parameters:
IR_LENGTH, 4, instruction register width (min 2)
IDCODE_VAL, 32'h1000_0001, value captured into the 32-bit IDCODE register (bit 0 must be 1)
INS_BYPASS, all ones (IR_LENGTH bits), BYPASS opcode
INS_IDCODE, 4'b0001, IDCODE opcode
INS_USER_DR, 4'b0010, opcode that selects the external user data register

Ports:
TCK  input  1  test clock, all state on posedge
TRST  input  1  asynchronous reset, active-high
TMS  input  1  test mode select, sampled on posedge TCK
TDI  input  1  serial data in, fanned to IR, BYPASS, IDCODE and user DR
DR_TDO  input  1  serial out of user data register (its shift MSB)
TDO  output  1  serial data out
TDO_EN  output  1  high only in Shift-DR or Shift-IR
tdr_select  output  1  high while IR == INS_USER_DR
Capture_DR  output  1  high while FSM in Capture-DR
Shift_DR  output  1  high while FSM in Shift-DR
Update_DR  output  1  high while FSM in Update-DR
IR_OUT  output  IR_LENGTH  current (updated) instruction
tap_state  output  4  current FSM state code, for debug

Behaviour:
- Clock and reset: one clock, TCK. Reset is TRST, asynchronous and active-high.
- TRST reset values: state = Test-Logic-Reset, IR = INS_IDCODE, IR shift reg = 0, bypass = 0, IDCODE shift reg = IDCODE_VAL. All strobes, TDO and TDO_EN are 0.
- State encodings (hex):
  - TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5
  - SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D
- Transitions on posedge TCK, written as (TMS=0 / TMS=1):
  - TLR->RTI/TLR; RTI->RTI/SelDR; SelDR->CapDR/SelIR; CapDR->ShDR/Ex1DR
  - ShDR->ShDR/Ex1DR; Ex1DR->PauDR/UpdDR; PauDR->PauDR/Ex2DR; Ex2DR->ShDR/UpdDR
  - UpdDR->RTI/SelDR; SelIR->CapIR/TLR; CapIR->ShIR/Ex1IR; ShIR->ShIR/Ex1IR
  - Ex1IR->PauIR/UpdIR; PauIR->PauIR/Ex2IR; Ex2IR->ShIR/UpdIR; UpdIR->RTI/SelDR
- Five consecutive TMS=1 clocks reach TLR from any state. Entering TLR, or any clock spent in TLR, reloads IR with INS_IDCODE synchronously.
- Strobes are combinational decodes of the current state (Moore outputs). The data register acts on the posedge that leaves the state, so:
  - Capture_DR is 1 for exactly one clock per CapDR visit.
  - Shift_DR is 1 once per shift cycle.
  - Update_DR is 1 for one clock.
- IR shift register:
  - In CapIR, loads {(IR_LENGTH-2) zeros, 2'b01}.
  - In ShIR, shifts left with TDI into the LSB.
  - IR serial out is its MSB.
  - In UpdIR, IR <= IR shift reg at the posedge leaving UpdIR.
- BYPASS: 1-bit register. Active only when the IR holds INS_BYPASS or any undefined opcode. Captures 0 in CapDR, loads TDI in ShDR.
- IDCODE: 32-bit register. Active only when IR == INS_IDCODE. Captures IDCODE_VAL in CapDR, shifts left with TDI into the LSB in ShDR, serial out is its MSB.
- Registers are inactive when not selected and hold their value.
- TDO mux (combinational, posedge-only design):
  - ShIR -> IR MSB.
  - ShDR -> DR_TDO if tdr_select, IDCODE MSB if IDCODE is selected, otherwise the bypass bit.
  - All other states -> 0.
- tdr_select follows IR_OUT. It changes only after UpdIR or on reset, never in mid-DR-scan.
- TRST asserted mid-shift: the FSM goes to TLR immediately (async) and all outputs return to reset values. Partial shift contents are discarded.

Decomposition:
- Package jtag_pkg holds:
  - the 16 TAP state encodings as named constants;
  - the default IR_LENGTH and the INS_BYPASS/INS_IDCODE/INS_USER_DR opcodes;
  - the IR capture pattern.
- One natural sub-module, tap_fsm: TMS/TCK/TRST in, 4-bit state out, with the strobe decode.
- IR, BYPASS, IDCODE and the TDO mux stay in the top level.

Test Plan:
- TRST pulse, then TMS=1 for 5 clocks from random states -> tap_state=F, IR_OUT=0001, all strobes 0, TDO_EN=0.
- IDCODE read: from RTI, TMS 1,0,0 to ShDR, 32 shifts -> TDO emits IDCODE_VAL MSB-first (0x10000001). Capture_DR is high exactly one clock.
- Load USER_DR: IR scan shifting TDI 0,0,1,0 with TMS=1 on the last bit, then UpdIR -> IR_OUT=0010, tdr_select=1.
  - TDO during the IR shift shows the capture pattern 0,0,0,1.
- User DR scan with a 5-bit Data_Reg attached: shift TDI 1,0,1,1,0 -> TDO shows 1,1,1,1,1 (captured ones).
  - After UpdDR the register's DR_OUT = 10110.
  - Update_DR is high for one clock.
- BYPASS: IR=1111, DR scan of 8 bits TDI=10110011 -> TDO is 0 then TDI delayed one clock (0,1,0,1,1,0,0,1).
- TRST during ShDR after 2 of 5 bits -> immediate TLR, IR_OUT=0001, tdr_select=0, no Update_DR pulse.
